// File: rtl/bus_arbiter.sv
// bus_arbiter: N-master system bus arbiter with fixed or round-robin priority.
// Optional hold-timeout preemption is compiled in when BUS_ARB_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | no grant; arbitrate on every edge with |req
// ST_OWN   | exactly one grant bit set; release on boundary

module bus_arbiter #(
  parameter int N        = 8,
  parameter int RR_MODE  = 1,
  parameter int HOLD_MAX = 16
) (
  input  logic                                  clk,
  input  logic                                  clr_n,
  input  logic [N-1:0]                          req,
  input  logic                                  BUS_req,
  input  logic                                  BUS_ready,
  output logic [N-1:0]                          grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  owner,
  output logic                                  bus_busy,
  output logic                                  preempt
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam logic [OW:0]   N_W    = (OW+1)'(N);
  localparam logic [OW-1:0] LAST   = OW'(N - 1);
  localparam logic [OW-1:0] ONE_OW = OW'(1);

  if (N < 1 || N > 32 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_param_check
    $error("bus_arbiter: N or HOLD_MAX out of range");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_d;
  logic [OW-1:0]   owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   sel_ptr;
  logic [N-1:0]    rot;
  logic [OW-1:0]   off;
  logic [OW:0]     sum;
  logic [OW-1:0]   win_idx;
  logic [OW-1:0]   ptr_next;
  logic            own_req;
  logic            boundary;
  logic            to_rel;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM  = 8'(HOLD_MAX);
  localparam logic [7:0] HOLD_TRIP = 8'(HOLD_MAX - 1);

  logic [7:0] hold_q, hold_d;
  logic       preempt_q, preempt_d;
  logic       others_req;

  assign others_req = |(req & ~grant);
  assign to_rel     = (hold_q >= HOLD_TRIP) && others_req;
  assign preempt    = preempt_q;
`else
  assign to_rel  = 1'b0;
  assign preempt = 1'b0;
`endif

  assign own_req  = |(req & grant);
  assign boundary = !BUS_req || BUS_ready;
  assign bus_busy = (state_q == ST_OWN);
  assign ptr_next = (owner == LAST) ? '0 : owner + ONE_OW;

  // Rotate requests so the search always starts at bit 0, then map the
  // lowest set offset back onto a master index modulo N.
  always_comb begin
    sel_ptr = (RR_MODE != 0) ? ptr_q : '0;
    rot     = N'({req, req} >> sel_ptr);
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = OW'(i);
    end
    sum = {1'b0, sel_ptr} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    win_idx = sum[OW-1:0];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    owner_d = owner;
    ptr_d   = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_OWN;
          owner_d = win_idx;
          for (int i = 0; i < N; i++) begin
            grant_d[i] = (win_idx == OW'(i));
          end
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d = '0;
`endif
        end
      end
      ST_OWN: begin
        if (boundary && (!own_req || to_rel)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
`ifdef BUS_ARB_TIMEOUT_EN
          // Still requesting at release means the timeout forced it out.
          preempt_d = own_req;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
          if (hold_q < HOLD_LIM) hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      grant   <= '0;
      owner   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      owner   <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: round-robin and fixed-priority instances share stimulus
// and are compared every cycle against a behavioural model.
module tb_bus_arbiter;

  localparam int N  = 8;
  localparam int HM = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr_n;
  logic [7:0] req;
  logic       bus_req, bus_ready;
  logic [7:0] grant_rr, grant_fx;
  logic [2:0] owner_rr, owner_fx;
  logic       busy_rr, busy_fx, pre_rr, pre_fx;

  always #5 clk = ~clk;

  bus_arbiter #(.N(N), .RR_MODE(1), .HOLD_MAX(HM)) dut_rr (
    .clk(clk), .clr_n(clr_n), .req(req), .BUS_req(bus_req), .BUS_ready(bus_ready),
    .grant(grant_rr), .owner(owner_rr), .bus_busy(busy_rr), .preempt(pre_rr));

  bus_arbiter #(.N(N), .RR_MODE(0), .HOLD_MAX(HM)) dut_fx (
    .clk(clk), .clr_n(clr_n), .req(req), .BUS_req(bus_req), .BUS_ready(bus_ready),
    .grant(grant_fx), .owner(owner_fx), .bus_busy(busy_fx), .preempt(pre_fx));

  int checks = 0;
  int errors = 0;

  // model state, index 0 = round-robin instance, 1 = fixed-priority instance
  bit m_busy [2];
  int m_owner[2];
  int m_ptr  [2];
  int m_hold [2];
  bit m_pre  [2];

  typedef struct {
    logic [7:0] r;
    bit         bq;
    bit         br;
    logic [7:0] exp_rr;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_owner[k] = 0; m_ptr[k] = 0; m_hold[k] = 0; m_pre[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int win;
    int c;
    bit bnd, vol, to;
    m_pre[k] = 1'b0;
    if (!m_busy[k]) begin
      if (req != 8'h00) begin
        win = -1;
        for (int i = 0; i < N; i++) begin
          c = (k == 0) ? (m_ptr[k] + i) % N : i;
          if (win < 0 && ((int'(req) >> c) & 1) == 1) win = c;
        end
        m_busy[k] = 1'b1; m_owner[k] = win; m_hold[k] = 0;
      end
    end else begin
      bnd = !bus_req || bus_ready;
      vol = ((int'(req) >> m_owner[k]) & 1) == 0;
      to  = TO_ON && (m_hold[k] >= HM - 1) && ((int'(req) & ~(1 << m_owner[k])) != 0);
      if (bnd && (vol || to)) begin
        m_busy[k] = 1'b0;
        m_ptr[k]  = (m_owner[k] + 1) % N;
        m_pre[k]  = !vol;
      end else begin
        m_hold[k]++;
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] eg;
    for (int k = 0; k < 2; k++) begin
      eg = m_busy[k] ? 8'(1 << m_owner[k]) : 8'h00;
      if (k == 0) begin
        chk("rr_grant", grant_rr, eg);
        chk("rr_owner", owner_rr, m_owner[k]);
        chk("rr_busy",  busy_rr,  m_busy[k]);
        chk("rr_preempt", pre_rr, m_pre[k]);
      end else begin
        chk("fx_grant", grant_fx, eg);
        chk("fx_owner", owner_fx, m_owner[k]);
        chk("fx_busy",  busy_fx,  m_busy[k]);
        chk("fx_preempt", pre_fx, m_pre[k]);
      end
    end
  endtask

  task automatic cycle(input logic [7:0] r, input bit bq, input bit br);
    req = r; bus_req = bq; bus_ready = br;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    req = 8'h00; bus_req = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    clr_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [7:0] r, input bit bq, input bit br, input logic [7:0] e);
    vec_t v;
    v.r = r; v.bq = bq; v.br = br; v.exp_rr = e;
    return v;
  endfunction

  initial begin
    logic [7:0] rr;
    logic [7:0] drops[3];
    logic [7:0] grants[3];
    clr_n = 1'b0; req = 8'h00; bus_req = 1'b0; bus_ready = 1'b0;

    // fairness table: each owner does one transfer, then drops its request once
    drops[0] = 8'h0C; drops[1] = 8'h09; drops[2] = 8'h05;
    grants[0] = 8'h01; grants[1] = 8'h04; grants[2] = 8'h08;
    for (int i = 0; i < 6; i++) begin
      tbl[3*i]   = mk(8'h0D, 1'b0, 1'b0, grants[i % 3]);
      tbl[3*i+1] = mk(8'h0D, 1'b1, 1'b1, grants[i % 3]);
      tbl[3*i+2] = mk(drops[i % 3], 1'b0, 1'b0, 8'h00);
    end

    // reset / idle
    do_reset();
    for (int i = 0; i < 5; i++) cycle(8'h00, 1'b0, 1'b0);

    // round-robin fairness
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].r, tbl[i].bq, tbl[i].br);
      chk("tbl_rr_grant", grant_rr, tbl[i].exp_rr);
      chk("tbl_rr_preempt", pre_rr, 1'b0);
    end

    // fixed priority: master 7 starves until req[1] drops
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(8'h82, 1'b0, 1'b0); chk("fx_prio_grant1", grant_fx, 8'h02);
      cycle(8'h80, 1'b0, 1'b0); chk("fx_prio_release", grant_fx, 8'h00);
    end
    cycle(8'h80, 1'b0, 1'b0); chk("fx_prio_grant7", grant_fx, 8'h80);

    // transfer protection
    do_reset();
    cycle(8'h04, 1'b0, 1'b0); chk("xfer_grant", grant_rr, 8'h04);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 1'b1, 1'b0); chk("xfer_hold", grant_rr, 8'h04);
    end
    cycle(8'h00, 1'b1, 1'b1); chk("xfer_release", grant_rr, 8'h00);
    cycle(8'h00, 1'b0, 1'b0); chk("xfer_idle", grant_rr, 8'h00);

    // hold timeout
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(8'h03, 1'b0, 1'b0);
      chk("to_hold_grant", grant_rr, 8'h01);
      chk("to_hold_preempt", pre_rr, 1'b0);
    end
    cycle(8'h03, 1'b0, 1'b0);
    chk("to_fire_grant", grant_rr, TO_ON ? 8'h00 : 8'h01);
    chk("to_fire_preempt", pre_rr, TO_ON);
    cycle(8'h03, 1'b0, 1'b0);
    chk("to_next_grant", grant_rr, TO_ON ? 8'h02 : 8'h01);
    chk("to_next_preempt", pre_rr, 1'b0);

    // asynchronous reset mid-ownership
    do_reset();
    cycle(8'h10, 1'b1, 1'b0); chk("async_own", grant_rr, 8'h10);
    #2;
    clr_n = 1'b0;
    model_reset();
    #1;
    chk("async_grant", grant_rr, 8'h00);
    chk("async_busy", busy_rr, 1'b0);
    compare_all();
    @(negedge clk);
    clr_n = 1'b1;
    cycle(8'h11, 1'b0, 1'b0); chk("async_first", grant_rr, 8'h01);

    // randomized traffic against the model
    do_reset();
    rr = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) begin
        rr = 8'($urandom) & 8'($urandom);
        if ($urandom_range(7) == 0) rr = 8'h00;
      end
      cycle(rr, 1'($urandom_range(1)), ($urandom_range(2) == 0));
      chk("rand_onehot_rr", 32'($countones(grant_rr) <= 1), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
